// File: rtl/walk_countdown_pkg.sv
// -----------------------------------------------------------------------------
// walk_countdown_pkg
// Shared definitions for the pedestrian countdown stage:
//   - state_e        : 2-bit countdown state encoding
//   - SEG_*          : seven-segment patterns {a,b,c,d,e,f,g}, bit6 = a,
//                      active-high, all-zero = blank
//   - saturate_load  : clamps a requested walk time to the displayable range
// -----------------------------------------------------------------------------
package walk_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FLASH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b111_1110;
    localparam logic [6:0] SEG_1     = 7'b011_0000;
    localparam logic [6:0] SEG_2     = 7'b110_1101;
    localparam logic [6:0] SEG_3     = 7'b111_1001;
    localparam logic [6:0] SEG_4     = 7'b011_0011;
    localparam logic [6:0] SEG_5     = 7'b101_1011;
    localparam logic [6:0] SEG_6     = 7'b101_1111;
    localparam logic [6:0] SEG_7     = 7'b111_0000;
    localparam logic [6:0] SEG_8     = 7'b111_1111;
    localparam logic [6:0] SEG_9     = 7'b111_1011;
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Walk times beyond what one digit can show are clamped, not wrapped.
    function automatic logic [3:0] saturate_load(input logic [3:0] t,
                                                 input logic [3:0] max_val);
        return (t > max_val) ? max_val : t;
    endfunction

endpackage

// File: rtl/walk_countdown_seg7_decoder.sv
// -----------------------------------------------------------------------------
// walk_countdown_seg7_decoder
// Combinational BCD-digit to seven-segment mapping. Values 10-15 blank.
// Ports:
//   digit_i [3:0] : value to display
//   seg_o   [6:0] : segments {a,b,c,d,e,f,g}, bit6 = a, active-high
// -----------------------------------------------------------------------------
module walk_countdown_seg7_decoder
    import walk_countdown_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: the default arm covers every unlisted code, so seg_o is
        // assigned on all paths and no latch is inferred.
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/walk_countdown.sv
// -----------------------------------------------------------------------------
// walk_countdown
// Pedestrian countdown that follows the traffic FSM's Walk output. Each new
// Walk phase loads walk_time (clamped to MAX_COUNT) and counts down once per
// Hz1_enable tick, showing the remaining seconds on one seven-segment digit.
// The last FLASH_AT seconds flash the DON'T-WALK lamp as a warning.
// Ports:
//   clk            : system clock (1 kHz)
//   Reset          : synchronous, active-high reset
//   Hz1_enable     : one-clk-wide 1 Hz tick
//   Walk           : walk phase active
//   walk_time[3:0] : walk duration in seconds, sampled on Walk rising
//   seg[6:0]       : segments {a..g}, bit6 = a, active-high, 0 = blank
//   walk_lamp      : steady WALK lamp
//   dont_walk_lamp : DON'T-WALK lamp (steady, or flashing during warning)
//   busy           : countdown in progress
// All outputs are registered.
// -----------------------------------------------------------------------------
module walk_countdown
    import walk_countdown_pkg::*;
#(
    parameter int MAX_COUNT = 9,
    parameter int FLASH_AT  = 3
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Hz1_enable,
    input  logic       Walk,
    input  logic [3:0] walk_time,
    output logic [6:0] seg,
    output logic       walk_lamp,
    output logic       dont_walk_lamp,
    output logic       busy
);

    localparam logic [3:0] MAX_C   = 4'(MAX_COUNT);
    localparam logic [3:0] FLASH_C = 4'(FLASH_AT);

    state_e     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       walk_d_q;
    logic [6:0] seg_q, seg_d;
    logic       walk_lamp_q, walk_lamp_d;
    logic       dont_walk_q, dont_walk_d;
    logic       busy_q, busy_d;

    logic       rise;
    logic [3:0] load;
    logic [6:0] digit_seg;

    assign rise = Walk & ~walk_d_q;

    // The decoder looks at the next count so the registered digit appears
    // on the same edge that updates the count.
    walk_countdown_seg7_decoder u_seg7_decoder (
        .digit_i (count_d),
        .seg_o   (digit_seg)
    );

    // Next-state and count update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = saturate_load(walk_time, MAX_C);

        unique case (state_q)
            IDLE: begin
                // A tick coincident with rise is ignored: the load wins.
                if (rise) begin
                    count_d = load;
                    if (load == 4'd0)          state_d = DONE;
                    else if (load <= FLASH_C)  state_d = FLASH;
                    else                       state_d = COUNT;
                end
            end
            COUNT: begin
                if (!Walk) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end else if (Hz1_enable && count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                    if (count_d <= FLASH_C) state_d = FLASH;
                end
            end
            FLASH: begin
                if (!Walk) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                end else if (Hz1_enable) begin
                    // count_q==0 is not reachable here; treating it like 1
                    // keeps the counter from ever wrapping.
                    if (count_q <= 4'd1) begin
                        count_d = 4'd0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q - 4'd1;
                    end
                end
            end
            DONE: begin
                count_d = 4'd0;
                if (!Walk) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase
    end

    // Registered outputs, derived from the next state so they line up with it.
    always_comb begin
        seg_d       = (state_d == IDLE) ? SEG_BLANK : digit_seg;
        walk_lamp_d = (state_d == COUNT);
        busy_d      = (state_d == COUNT) || (state_d == FLASH);
        dont_walk_d = 1'b1;
        if (state_d == COUNT) begin
            dont_walk_d = 1'b0;
        end else if (state_d == FLASH && state_q == FLASH) begin
            // Staying in FLASH: flip on every tick; entering FLASH starts lit.
            dont_walk_d = Hz1_enable ? ~dont_walk_q : dont_walk_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values; blocking here would chain updates within one edge.
        if (Reset) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            walk_d_q    <= 1'b0;
            seg_q       <= SEG_BLANK;
            walk_lamp_q <= 1'b0;
            dont_walk_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            walk_d_q    <= Walk;
            seg_q       <= seg_d;
            walk_lamp_q <= walk_lamp_d;
            dont_walk_q <= dont_walk_d;
            busy_q      <= busy_d;
        end
    end

    assign seg            = seg_q;
    assign walk_lamp      = walk_lamp_q;
    assign dont_walk_lamp = dont_walk_q;
    assign busy           = busy_q;

endmodule
